fre_calc: RTL and testbench

Consumer-side companion to the frequency-measurement path. It captures the standard-count/signal-count pair (M, N) at the end of each measurement gate and computes fre = N * CLK_FREQ / M as unsigned fixed-point Hz. The computation uses a one-bit-per-clock restoring divider. The result is presented to the register bank / display logic with a single-cycle valid strobe.

---
 rtl/fre_calc.sv | 126 ++++++++++++
 tb/tb_fre_calc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fre_calc.sv
// Frequency calculator: captures (M, N) at gate end and computes N*CLK_FREQ/M
// as unsigned fixed point, one quotient bit per clock (restoring divider).
module fre_calc #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int FRAC_BITS = 8,
   parameter int OUT_W     = 40,
   parameter int DIV_W     = 72
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic [31:0]      M_in,
   input  logic [31:0]      N_in,
   input  logic             irq,
   output logic [OUT_W-1:0] fre_out,
   output logic             fre_valid,
   output logic             busy,
   output logic             sat,
   output logic             err,
   output logic             overrun
);

   localparam int CNT_W = $clog2(DIV_W);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       r_state;
   logic             r_irq_d;
   logic [31:0]      r_m;
   logic [31:0]      r_n;
   logic [31:0]      r_rem;
   logic [DIV_W-1:0] r_dvd;
   logic [CNT_W-1:0] r_cnt;
   logic [OUT_W-1:0] r_fre;
   logic             r_valid, r_busy, r_sat, r_err, r_ovr;

   logic             w_cap;
   logic [DIV_W-1:0] w_dvd0;
   logic [32:0]      w_rem_sh;
   logic             w_ge;
   logic [31:0]      w_diff;
   logic [DIV_W-1:0] w_q;
   logic             w_ovf;

   assign w_cap    = r_irq_d & ~irq;
   assign w_dvd0   = (DIV_W'(r_n) * DIV_W'(CLK_FREQ)) << FRAC_BITS;
   // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
   assign w_rem_sh = {r_rem, r_dvd[DIV_W-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_m});
   // True difference is < M, so the 32-bit modular result is exact.
   assign w_diff   = w_rem_sh[31:0] - r_m;
   assign w_q      = {r_dvd[DIV_W-2:0], w_ge};
   assign w_ovf    = |w_q[DIV_W-1:OUT_W];

   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_irq_d <= 1'b0;
         r_m     <= '0;
         r_n     <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_cnt   <= '0;
         r_fre   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_sat   <= 1'b0;
         r_err   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_irq_d <= irq;
         r_valid <= 1'b0;
         r_ovr   <= w_cap && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_cap) begin
                  r_m     <= M_in;
                  r_n     <= N_in;
                  r_busy  <= 1'b1;
                  r_state <= MUL;
               end
            end
            MUL: begin
               if (r_m == '0) begin
                  r_fre   <= '1;
                  r_sat   <= 1'b1;
                  r_err   <= 1'b1;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_dvd   <= w_dvd0;
                  r_rem   <= '0;
                  r_cnt   <= CNT_W'(DIV_W - 1);
                  r_state <= DIV;
               end
            end
            DIV: begin
               r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
               r_dvd <= w_q;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_fre   <= w_ovf ? '1 : w_q[OUT_W-1:0];
                  r_sat   <= w_ovf;
                  r_err   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fre_out   = r_fre;
   assign fre_valid = r_valid;
   assign busy      = r_busy;
   assign sat       = r_sat;
   assign err       = r_err;
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_fre_calc.sv
// Directed-vector bench for fre_calc: table of (M, N, expected) plus
// sequences for overrun, back-to-back capture and mid-division reset.
module tb_fre_calc;

   logic        clk_100M = 1'b0;
   logic        rst;
   logic [31:0] M_in, N_in;
   logic        irq;
   logic [39:0] fre_out;
   logic        fre_valid, busy, sat, err, overrun;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [39:0] ONES = 40'hFF_FFFF_FFFF;

   fre_calc dut (
      .clk_100M(clk_100M), .rst(rst), .M_in(M_in), .N_in(N_in), .irq(irq),
      .fre_out(fre_out), .fre_valid(fre_valid), .busy(busy), .sat(sat),
      .err(err), .overrun(overrun)
   );

   always #5 clk_100M = ~clk_100M;

   typedef struct {
      logic [31:0] m;
      logic [31:0] n;
      logic [39:0] fre;
      logic        sat;
      logic        err;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Raise irq for one cycle, then drop it; capture happens at the next posedge.
   task automatic start(input logic [31:0] m, input logic [31:0] n);
      M_in = m; N_in = n; irq = 1'b1;
      @(negedge clk_100M);
      irq = 1'b0;
   endtask

   // Returns at the negedge of the fre_valid cycle.
   task automatic wait_result(input string name, input int lat, input logic [39:0] efre,
                              input logic esat, input logic eerr);
      int got = -1;
      int busy_lo = 0;
      int ovr = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk_100M);
         @(negedge clk_100M);
         if (!busy) busy_lo++;
         if (overrun) ovr++;
         if (fre_valid) begin
            got = k;
            break;
         end
      end
      chk({name, " latency"}, 64'(got), 64'(lat));
      chk({name, " fre_out"}, 64'(fre_out), 64'(efre));
      chk({name, " sat"}, 64'(sat), 64'(esat));
      chk({name, " err"}, 64'(err), 64'(eerr));
      chk({name, " busy gaps"}, 64'(busy_lo), 64'd0);
      chk({name, " overrun"}, 64'(ovr), 64'd0);
   endtask

   function automatic logic [39:0] ref_fre(input logic [31:0] m, input logic [31:0] n,
                                           output logic s);
      logic [127:0] q;
      q = ({96'd0, n} * 128'd100_000_000 * 128'd256) / {96'd0, m};
      s = (q >= (128'd1 << 40));
      return s ? ONES : q[39:0];
   endfunction

   vec_t tbl[$];

   initial begin
      logic        rs;
      logic [39:0] rf;
      logic [31:0] rm, rn;
      int          cnt;

      tbl.push_back('{32'd100_000_000, 32'd1000,       40'd256_000,        1'b0, 1'b0, 74});
      tbl.push_back('{32'd100_000_000, 32'd25_000_000, 40'd6_400_000_000,  1'b0, 1'b0, 74});
      tbl.push_back('{32'd3,           32'd1,          40'd8_533_333_333,  1'b0, 1'b0, 74});
      tbl.push_back('{32'd1,           32'hFFFF_FFFF,  ONES,               1'b1, 1'b0, 74});
      tbl.push_back('{32'd0,           32'd5,          ONES,               1'b1, 1'b1, 2});
      tbl.push_back('{32'd7,           32'd0,          40'd0,              1'b0, 1'b0, 74});
      tbl.push_back('{32'd99_999_999,  32'd12345,      40'd3_160_320,      1'b0, 1'b0, 74});
      tbl.push_back('{32'd1,           32'd42,         40'd1_075_200_000_000, 1'b0, 1'b0, 74});
      tbl.push_back('{32'd1,           32'd43,         ONES,               1'b1, 1'b0, 74});
      tbl.push_back('{32'hFFFF_FFFF,   32'hFFFF_FFFF,  40'd25_600_000_000, 1'b0, 1'b0, 74});
      tbl.push_back('{32'hFFFF_FFFF,   32'd7,          40'd41,             1'b0, 1'b0, 74});

      rst = 1'b1; irq = 1'b0; M_in = '0; N_in = '0;
      repeat (3) @(negedge clk_100M);
      chk("reset fre_out", 64'(fre_out), 64'd0);
      chk("reset flags", 64'({fre_valid, busy, sat, err, overrun}), 64'd0);
      rst = 1'b0;
      @(negedge clk_100M);

      foreach (tbl[i]) begin
         start(tbl[i].m, tbl[i].n);
         wait_result($sformatf("vec%0d", i), tbl[i].lat, tbl[i].fre, tbl[i].sat, tbl[i].err);
         @(negedge clk_100M);
         chk($sformatf("vec%0d busy after", i), 64'(busy), 64'd0);
         chk($sformatf("vec%0d valid 1 cycle", i), 64'(fre_valid), 64'd0);
         @(negedge clk_100M);
      end

      // Second gate end mid-division: overrun, first result unaffected.
      start(32'd100_000_000, 32'd1000);
      repeat (19) @(negedge clk_100M);
      M_in = 32'd5; N_in = 32'd9; irq = 1'b1;
      @(negedge clk_100M);
      irq = 1'b0;
      cnt = 0;
      begin
         int got = -1;
         for (int k = 1; k <= 120; k++) begin
            @(posedge clk_100M);
            @(negedge clk_100M);
            if (overrun) cnt++;
            if (fre_valid && got < 0) begin
               got = k;
               chk("ovr fre_out", 64'(fre_out), 64'd256_000);
            end else if (fre_valid) begin
               chk("ovr second valid", 64'd1, 64'd0);
            end
         end
         chk("ovr result seen", 64'(got > 0), 64'd1);
         chk("ovr pulses", 64'(cnt), 64'd1);
         chk("ovr fre_out held", 64'(fre_out), 64'd256_000);
      end

      // Capture the cycle after DONE is accepted.
      start(32'd100_000_000, 32'd25_000_000);
      wait_result("b2b first", 74, 40'd6_400_000_000, 1'b0, 1'b0);
      start(32'd3, 32'd1);
      wait_result("b2b second", 74, 40'd8_533_333_333, 1'b0, 1'b0);
      repeat (2) @(negedge clk_100M);

      // Async reset in the middle of DIV.
      start(32'd1, 32'd43);
      repeat (31) @(negedge clk_100M);
      #2 rst = 1'b1;
      #1;
      chk("midrst fre_out", 64'(fre_out), 64'd0);
      chk("midrst flags", 64'({fre_valid, busy, sat, err, overrun}), 64'd0);
      @(negedge clk_100M);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_100M);
         if (fre_valid || busy) cnt++;
      end
      chk("midrst no activity", 64'(cnt), 64'd0);
      start(32'd99_999_999, 32'd12345);
      wait_result("post rst", 74, 40'd3_160_320, 1'b0, 1'b0);
      @(negedge clk_100M);

      // Random pairs against a wide-arithmetic reference.
      for (int r = 0; r < 150; r++) begin
         rn = $urandom;
         rm = (r % 3 == 0) ? 32'($urandom_range(1, 2000)) : $urandom;
         if (rm == 0) rm = 1;
         rf = ref_fre(rm, rn, rs);
         start(rm, rn);
         wait_result($sformatf("rnd%0d m=%0d n=%0d", r, rm, rn), 74, rf, rs, 1'b0);
         @(negedge clk_100M);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
